// File: rtl/led_cmd_pkg.sv
// -----------------------------------------------------------------------------
// led_cmd_pkg
// Shared definitions for the byte-command PWM LED controller: command opcodes,
// command FSM state encoding and the blink tick divider derived from the clock.
// -----------------------------------------------------------------------------
package led_cmd_pkg;

    localparam logic [2:0] OP_SET_DUTY  = 3'd0;
    localparam logic [2:0] OP_SET_BLINK = 3'd1;
    localparam logic [2:0] OP_READ_DUTY = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ARG = 2'd1,
        ST_RESP     = 2'd2
    } cmd_state_e;

    // Cycles per 10 ms blink tick; never below 1 so the divider stays valid
    // for very slow simulation clocks.
    function automatic int unsigned TICK_DIV(input int unsigned clk_hz);
        int unsigned d;
        d = clk_hz / 100;
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/led_cmd_pwm_if.sv
// -----------------------------------------------------------------------------
// led_cmd_pwm_if
// Command/response byte link between the UART front end and the LED controller.
//   cmd_valid  : one-cycle strobe, cmd_data holds a command byte
//   cmd_data   : command byte
//   resp_ready : downstream (UART transmitter) accepts resp_data
//   resp_valid : response byte available
//   resp_data  : response byte
// master = command source / response sink, slave = the LED controller.
// -----------------------------------------------------------------------------
interface led_cmd_pwm_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       resp_ready;
    logic       resp_valid;
    logic [7:0] resp_data;

    modport master (
        output cmd_valid, cmd_data, resp_ready,
        input  resp_valid, resp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, resp_ready,
        output resp_valid, resp_data
    );
endinterface

// File: rtl/led_pwm_chan.sv
// -----------------------------------------------------------------------------
// led_pwm_chan
// One PWM LED channel: pending/active duty registers, wrap-synchronous load,
// compare against the shared counter and a registered, polarity-adjusted output.
//   clk48, rst    : clock, asynchronous active-high reset
//   pwm_cnt_i     : shared free-running PWM counter
//   wrap_i        : high on the cycle pwm_cnt_i is at its maximum
//   blink_on_i    : global blink phase (0 forces the LED dark)
//   wr_en_i       : load wr_duty_i into the pending register
//   wr_duty_i     : new duty value
//   act_duty_o    : duty currently in effect (for readback)
//   led_o         : registered LED drive
// -----------------------------------------------------------------------------
module led_pwm_chan #(
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk48,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                wrap_i,
    input  logic                blink_on_i,
    input  logic                wr_en_i,
    input  logic [PWM_BITS-1:0] wr_duty_i,
    output logic [PWM_BITS-1:0] act_duty_o,
    output logic                led_o
);

    logic [PWM_BITS-1:0] pend_q;
    logic [PWM_BITS-1:0] act_q;
    logic                led_q;
    logic                lit_d;

    assign lit_d = blink_on_i && (pwm_cnt_i < act_q);

    // The active duty only changes on the wrap cycle, so a period is never cut
    // short. A write landing on the wrap cycle reaches pend_q one cycle too
    // late for this load and takes effect at the following wrap.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            act_q  <= '0;
            led_q  <= ACTIVE_LOW;
        end else begin
            if (wr_en_i) begin
                pend_q <= wr_duty_i;
            end
            if (wrap_i) begin
                act_q <= pend_q;
            end
            led_q <= lit_d ^ ACTIVE_LOW;
        end
    end

    assign act_duty_o = act_q;
    assign led_o      = led_q;

endmodule

// File: rtl/led_cmd_pwm.sv
// -----------------------------------------------------------------------------
// led_cmd_pwm
// Byte-command-driven multi-channel PWM LED controller with global blink.
//   clk48  : sole clock
//   rst    : asynchronous active-high reset
//   bus    : command/response byte link (slave side)
//   led    : registered LED drives, one per channel
// Commands: header byte {1, opcode[2:0], channel[3:0]}
//   SET_DUTY  (0) + duty byte
//   SET_BLINK (1) + half-period byte in 10 ms ticks (0 = solid)
//   READ_DUTY (2) -> one response byte with the channel's active duty
// -----------------------------------------------------------------------------
module led_cmd_pwm
    import led_cmd_pkg::*;
#(
    parameter int          CHANNELS   = 3,
    parameter int          PWM_BITS   = 8,
    parameter int unsigned CLK_HZ     = 48000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clk48,
    input  logic                rst,
    led_cmd_pwm_if.slave        bus,
    output logic [CHANNELS-1:0] led
);

    localparam int unsigned TDIV   = TICK_DIV(CLK_HZ);
    localparam int          TICK_W = (TDIV > 1) ? $clog2(TDIV) : 1;

    // Shared PWM counter
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                wrap;

    // Blink timer
    logic [TICK_W-1:0]   div_q;
    logic                tick;
    logic [7:0]          blink_per_q;
    logic [7:0]          blink_cnt_q;
    logic                blink_ph_q;
    logic                blink_on;

    // Command FSM
    cmd_state_e          state_q, state_d;
    logic [2:0]          op_q;
    logic [3:0]          ch_q;
    logic                hdr_ok;
    logic                arg_stb;
    logic                blink_wr;
    logic                rd_hdr;
    logic                resp_valid_q;
    logic [7:0]          resp_data_q;
    logic [7:0]          rd_duty;

    // Channel datapath
    logic [CHANNELS-1:0] wr_en;
    logic [PWM_BITS-1:0] wr_duty;
    logic [PWM_BITS-1:0] act_duty [CHANNELS];

    assign wrap     = &pwm_cnt_q;
    assign tick     = (div_q == TICK_W'(TDIV - 1));
    assign blink_on = (blink_per_q == 8'd0) || blink_ph_q;

    assign hdr_ok   = bus.cmd_valid && bus.cmd_data[7];
    assign arg_stb  = (state_q == ST_WAIT_ARG) && bus.cmd_valid;
    assign blink_wr = arg_stb && (op_q == OP_SET_BLINK);
    assign rd_hdr   = (state_q == ST_IDLE) && hdr_ok && (bus.cmd_data[6:4] == OP_READ_DUTY);

    // Size cast truncates to PWM_BITS or zero-extends the argument byte.
    assign wr_duty  = PWM_BITS'(bus.cmd_data);

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_en[i] = arg_stb && (op_q == OP_SET_DUTY) && (ch_q == 4'(i));
        end
    end

    // Out-of-range channels match nothing and read back as 0x00.
    always_comb begin
        rd_duty = 8'h00;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.cmd_data[3:0] == 4'(i)) begin
                rd_duty = 8'(act_duty[i]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_ok) begin
                    if ((bus.cmd_data[6:4] == OP_SET_DUTY) || (bus.cmd_data[6:4] == OP_SET_BLINK)) begin
                        state_d = ST_WAIT_ARG;
                    end else if (bus.cmd_data[6:4] == OP_READ_DUTY) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT_ARG: begin
                if (bus.cmd_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (resp_valid_q && bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            ch_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && hdr_ok) begin
                op_q <= bus.cmd_data[6:4];
                ch_q <= bus.cmd_data[3:0];
            end
        end
    end

    // Response byte is captured at the header and held until the handshake.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
        end else if (rd_hdr) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= rd_duty;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    // Writing the blink period restarts the tick prescaler and tick count and
    // turns the phase on, so the first half-period is always a full one.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            blink_per_q <= 8'd0;
            blink_cnt_q <= 8'd0;
            blink_ph_q  <= 1'b1;
        end else if (blink_wr) begin
            div_q       <= '0;
            blink_per_q <= bus.cmd_data;
            blink_cnt_q <= 8'd0;
            blink_ph_q  <= 1'b1;
        end else begin
            div_q <= tick ? '0 : div_q + TICK_W'(1);
            if (tick) begin
                if (blink_per_q == 8'd0) begin
                    blink_cnt_q <= 8'd0;
                    blink_ph_q  <= 1'b1;
                end else if (blink_cnt_q + 8'd1 == blink_per_q) begin
                    blink_cnt_q <= 8'd0;
                    blink_ph_q  <= ~blink_ph_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk48      (clk48),
            .rst        (rst),
            .pwm_cnt_i  (pwm_cnt_q),
            .wrap_i     (wrap),
            .blink_on_i (blink_on),
            .wr_en_i    (wr_en[g]),
            .wr_duty_i  (wr_duty),
            .act_duty_o (act_duty[g]),
            .led_o      (led[g])
        );
    end

endmodule

// File: tb/tb_led_cmd_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_cmd_pwm
// Directed bench for led_cmd_pwm: CHANNELS=3, PWM_BITS=8, CLK_HZ=25600
// (blink tick every 256 cycles), active-low outputs.
// -----------------------------------------------------------------------------
module tb_led_cmd_pwm;

    logic       clk48 = 1'b0;
    logic       rst;
    logic [2:0] led;

    always #5 clk48 = ~clk48;

    led_cmd_pwm_if bus();

    led_cmd_pwm #(
        .CHANNELS   (3),
        .PWM_BITS   (8),
        .CLK_HZ     (25600),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk48 (clk48),
        .rst   (rst),
        .bus   (bus),
        .led   (led)
    );

    typedef struct packed {
        logic [7:0] hdr;
        logic [7:0] arg;
        logic [7:0] rd_hdr;
        logic [7:0] exp_resp;
    } vec_t;

    vec_t vecs [8];
    int   vec_cnt = 0;
    int   miscmp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk48); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        @(posedge clk48); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
    endtask

    // Sends a READ_DUTY header and checks the single response byte; resp_ready
    // is expected to be high so the handshake completes on the next edge.
    task automatic read_check(input string name, input logic [7:0] hdr, input logic [7:0] exp);
        logic       got;
        logic [7:0] data;
        got  = 1'b0;
        data = 8'h00;
        send_byte(hdr);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk48);
            if (bus.resp_valid === 1'b1) begin
                got  = 1'b1;
                data = bus.resp_data;
                break;
            end
        end
        chk({name, "_valid"}, 32'(got), 32'd1);
        chk(name, 32'(data), 32'(exp));
        @(posedge clk48); #1;
    endtask

    // Counts samples where led equals pat over n consecutive cycles.
    task automatic count_pat(input int n, input logic [2:0] pat, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk48);
            if (led === pat) cnt++;
        end
    endtask

    // Counts cycles each LED is lit (driven low) over n consecutive cycles.
    task automatic count_low(input int n, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk48);
            if (led[0] === 1'b0) c0++;
            if (led[1] === 1'b0) c1++;
            if (led[2] === 1'b0) c2++;
        end
    endtask

    initial begin
        int   bad, c0, c1, c2, cnt;
        logic found, prev;

        vecs[0] = '{hdr: 8'h80, arg: 8'h11, rd_hdr: 8'hA0, exp_resp: 8'h11};
        vecs[1] = '{hdr: 8'h82, arg: 8'hFF, rd_hdr: 8'hA2, exp_resp: 8'hFF};
        vecs[2] = '{hdr: 8'h81, arg: 8'hC5, rd_hdr: 8'hA1, exp_resp: 8'hC5};
        vecs[3] = '{hdr: 8'h85, arg: 8'h77, rd_hdr: 8'hA5, exp_resp: 8'h00};
        vecs[4] = '{hdr: 8'h8F, arg: 8'h33, rd_hdr: 8'hAF, exp_resp: 8'h00};
        vecs[5] = '{hdr: 8'h80, arg: 8'h2A, rd_hdr: 8'hA0, exp_resp: 8'h2A};
        vecs[6] = '{hdr: 8'h82, arg: 8'h01, rd_hdr: 8'hA1, exp_resp: 8'hC5};
        vecs[7] = '{hdr: 8'hB0, arg: 8'h55, rd_hdr: 8'hA0, exp_resp: 8'h2A};

        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = 8'h00;
        bus.resp_ready = 1'b1;
        rst            = 1'b1;

        // Reset state and hold
        repeat (3) @(posedge clk48);
        #1;
        chk("reset_led", 32'(led), 32'h7);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_resp_data", 32'(bus.resp_data), 32'h00);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk48);
            if (led !== 3'b111 || bus.resp_valid !== 1'b0) bad++;
        end
        chk("reset_hold_bad_cycles", 32'(bad), 32'd0);

        // SET_DUTY ch1 = 0x40
        send_byte(8'h81);
        send_byte(8'h40);
        repeat (300) @(posedge clk48);
        count_low(256, c0, c1, c2);
        chk("duty40_ch1_lit", 32'(c1), 32'd64);
        chk("duty40_ch0_lit", 32'(c0), 32'd0);
        chk("duty40_ch2_lit", 32'(c2), 32'd0);

        // READ_DUTY under backpressure, byte sent meanwhile is dropped
        bus.resp_ready = 1'b0;
        send_byte(8'hA1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk48);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'h40) bad++;
        end
        send_byte(8'h85);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk48);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'h40) bad++;
        end
        chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
        chk("bp_data", 32'(bus.resp_data), 32'h40);
        bus.resp_ready = 1'b1;
        @(posedge clk48); #1;
        chk("bp_release_valid", 32'(bus.resp_valid), 32'd0);
        read_check("bp_followup_read", 8'hA1, 8'h40);

        // Pending duty stays pending until the wrap: sync to the start of a
        // PWM period via ch1's lit edge, write, and read back at once.
        found = 1'b0;
        @(negedge clk48);
        prev = led[1];
        for (int i = 0; i < 600; i++) begin
            @(negedge clk48);
            if (prev === 1'b1 && led[1] === 1'b0) begin
                found = 1'b1;
                break;
            end
            prev = led[1];
        end
        chk("period_sync_found", 32'(found), 32'd1);
        send_byte(8'h81);
        send_byte(8'h10);
        read_check("pending_not_active", 8'hA1, 8'h40);
        repeat (300) @(posedge clk48);
        #1;
        read_check("active_after_wrap", 8'hA1, 8'h10);

        // Table of write/readback vectors
        for (int i = 0; i < 8; i++) begin
            send_byte(vecs[i].hdr);
            send_byte(vecs[i].arg);
            repeat (300) @(posedge clk48);
            #1;
            read_check($sformatf("tbl%0d_read", i), vecs[i].rd_hdr, vecs[i].exp_resp);
        end

        // Blink with half-period 2 ticks (512 cycles)
        send_byte(8'h80); send_byte(8'h80);
        send_byte(8'h81); send_byte(8'h80);
        send_byte(8'h82); send_byte(8'h80);
        repeat (300) @(posedge clk48);
        send_byte(8'h90);
        send_byte(8'h02);
        repeat (20) @(posedge clk48);
        count_pat(256, 3'b000, cnt);
        chk("blink_on1_lit", 32'(cnt), 32'd128);
        repeat (325) @(posedge clk48);
        count_pat(256, 3'b111, cnt);
        chk("blink_off_dark", 32'(cnt), 32'd256);
        repeat (245) @(posedge clk48);
        count_pat(256, 3'b000, cnt);
        chk("blink_on2_lit", 32'(cnt), 32'd128);

        // Solid again
        send_byte(8'h90);
        send_byte(8'h00);
        count_pat(1024, 3'b000, cnt);
        chk("solid_lit", 32'(cnt), 32'd512);

        // Out-of-range SET_DUTY changes nothing
        send_byte(8'h8F);
        send_byte(8'h33);
        repeat (300) @(posedge clk48);
        count_pat(256, 3'b000, cnt);
        chk("oor_write_lit", 32'(cnt), 32'd128);
        read_check("oor_read", 8'hAF, 8'h00);

        // Ignored bytes in IDLE
        send_byte(8'hF0);
        send_byte(8'h12);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk48);
            if (bus.resp_valid !== 1'b0) bad++;
        end
        chk("ignored_no_resp", 32'(bad), 32'd0);
        read_check("ignored_then_read", 8'hA2, 8'h80);

        // Reset in WAIT_ARG: next byte is a header
        send_byte(8'h80);
        @(posedge clk48); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk48);
        #1;
        chk("midcmd_reset_led", 32'(led), 32'h7);
        rst = 1'b0;
        read_check("midcmd_reset_read", 8'hA0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
